alu_seq_hs: RTL and testbench

//  Parametrised multi-cycle ALU with valid/ready handshake on input and output.

---
 rtl/alu_seq_hs_if.sv | 28 ++
 rtl/alu_seq_hs.sv | 168 ++++++++++++++++
 tb/tb_alu_seq_hs.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_hs_if.sv
// Operand/result handshake bundle for alu_seq_hs.
// The source/sink side uses the master modport; the ALU uses the slave modport.
interface alu_seq_hs_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       oper;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cy;
  logic             ovf;
  logic             dz;
  logic             zf;

  modport master (
    output in_valid, a, b, oper, out_ready,
    input  in_ready, out_valid, y, cy, ovf, dz, zf
  );

  modport slave (
    input  in_valid, a, b, oper, out_ready,
    output in_ready, out_valid, y, cy, ovf, dz, zf
  );
endinterface

// File: rtl/alu_seq_hs.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle add/sub/mul/and/or,
// WIDTH-cycle restoring div/mod and square-and-multiply pow.
module alu_seq_hs #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst_n,
  alu_seq_hs_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011,
    OP_POW = 3'b100, OP_MOD = 3'b101, OP_AND = 3'b110, OP_OR  = 3'b111
  } oper_e;

  state_e             state_q, state_d;
  oper_e              op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // r: remainder (div/mod) or accumulator (pow); x: quotient or base; e: divisor or exponent
  logic [WIDTH-1:0]   r_q, r_d, x_q, x_d, e_q, e_d;
  logic               bov_q, bov_d, pov_q, pov_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               cy_q, cy_d, ovf_q, ovf_d, dz_q, dz_d, zf_q, zf_d;

  logic               accept, start_calc, last_iter;
  logic [WIDTH:0]     sum, diff, rem_sh, rem_sub;
  logic [2*WIDTH-1:0] prod, mul_acc, mul_sq;
  logic [WIDTH-1:0]   rem_nx, quo_nx, acc_nx;
  logic               pov_nx;
  logic               load_res, res_cy, res_ovf, res_dz;
  logic [WIDTH-1:0]   res_y;

  assign accept     = bus.in_valid && (state_q == S_IDLE);
  assign start_calc = (bus.oper == OP_POW) ||
                      (((bus.oper == OP_DIV) || (bus.oper == OP_MOD)) && (bus.b != '0));
  assign last_iter  = (cnt_q == CNT_W'(WIDTH - 1));

  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};
  assign prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  // One iteration of either iterative algorithm, evaluated from the current registers.
  always_comb begin : dp_step
    rem_sh  = {r_q, x_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, e_q};
    rem_nx  = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
    quo_nx  = {x_q[WIDTH-2:0], ~rem_sub[WIDTH]};
    mul_acc = {{WIDTH{1'b0}}, r_q} * {{WIDTH{1'b0}}, x_q};
    mul_sq  = {{WIDTH{1'b0}}, x_q} * {{WIDTH{1'b0}}, x_q};
    acc_nx  = e_q[0] ? mul_acc[WIDTH-1:0] : r_q;
    // An acc multiply by a base that has already wrapped is itself an overflow.
    pov_nx  = pov_q | (e_q[0] & (bov_q | (|mul_acc[2*WIDTH-1:WIDTH])));
  end

  always_comb begin : dp_next
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    op_d     = op_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    x_d      = x_q;
    e_d      = e_q;
    bov_d    = bov_q;
    pov_d    = pov_q;
    load_res = 1'b0;
    res_y    = '0;
    res_cy   = 1'b0;
    res_ovf  = 1'b0;
    res_dz   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d     = oper_e'(bus.oper);
        cnt_d    = '0;
        x_d      = bus.a;
        e_d      = bus.b;
        bov_d    = 1'b0;
        pov_d    = 1'b0;
        r_d      = (bus.oper == OP_POW) ? WIDTH'(1) : '0;
        load_res = !start_calc;
        case (bus.oper)
          OP_ADD:  begin res_y = sum[WIDTH-1:0];  res_cy  = sum[WIDTH];  end
          OP_SUB:  begin res_y = diff[WIDTH-1:0]; res_cy  = diff[WIDTH]; end
          OP_MUL:  begin res_y = prod[WIDTH-1:0]; res_ovf = |prod[2*WIDTH-1:WIDTH]; end
          OP_DIV:  begin res_y = '1;    res_dz = 1'b1; end
          OP_MOD:  begin res_y = bus.a; res_dz = 1'b1; end
          OP_AND:  res_y = bus.a & bus.b;
          OP_OR:   res_y = bus.a | bus.b;
          default: res_y = '0;
        endcase
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_POW) begin
          r_d   = acc_nx;
          x_d   = mul_sq[WIDTH-1:0];
          e_d   = e_q >> 1;
          bov_d = bov_q | (|mul_sq[2*WIDTH-1:WIDTH]);
          pov_d = pov_nx;
        end else begin
          r_d = rem_nx;
          x_d = quo_nx;
        end
        if (last_iter) begin
          load_res = 1'b1;
          res_y    = (op_q == OP_POW) ? acc_nx : ((op_q == OP_MOD) ? rem_nx : quo_nx);
          res_ovf  = (op_q == OP_POW) && pov_nx;
        end
      end
      default: ;
    endcase
    y_d   = load_res ? res_y : y_q;
    cy_d  = load_res ? res_cy : cy_q;
    ovf_d = load_res ? res_ovf : ovf_q;
    dz_d  = load_res ? res_dz : dz_q;
    zf_d  = load_res ? (res_y == '0) : zf_q;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = start_calc ? S_CALC : S_DONE;
      S_CALC:  if (last_iter) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : fsm_out
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
  end

  assign bus.y   = y_q;
  assign bus.cy  = cy_q;
  assign bus.ovf = ovf_q;
  assign bus.dz  = dz_q;
  assign bus.zf  = zf_q;

  always_ff @(posedge clk) begin : ctrl_regs
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      zf_q    <= zf_d;
    end
  end

  // NOTE: the datapath is fully reloaded on every accept, so it carries no reset.
  always_ff @(posedge clk) begin : dp_regs
    op_q  <= op_d;
    cnt_q <= cnt_d;
    r_q   <= r_d;
    x_q   <= x_d;
    e_q   <= e_d;
    bov_q <= bov_d;
    pov_q <= pov_d;
  end
endmodule

// File: tb/tb_alu_seq_hs.sv
// Self-checking bench for alu_seq_hs (WIDTH=32): directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_alu_seq_hs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_seq_hs_if #(.WIDTH(32)) bus ();

  alu_seq_hs #(.WIDTH(32), .CNT_W(6)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definition of each operation.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                output logic [31:0] y, output logic cy, output logic ovf,
                                output logic dz, output int lat);
    longint unsigned la = a;
    longint unsigned lb = b;
    longint unsigned full;
    longint unsigned t;
    cy = 1'b0; ovf = 1'b0; dz = 1'b0; lat = 1; y = '0;
    case (op)
      3'd0: begin full = la + lb; y = full[31:0]; cy = (full >= 64'h1_0000_0000); end
      3'd1: begin y = a - b; cy = (a < b); end
      3'd2: begin full = la * lb; y = full[31:0]; ovf = (full >= 64'h1_0000_0000); end
      3'd3: if (b == 0) begin y = 32'hFFFF_FFFF; dz = 1'b1; end else begin y = a / b; lat = 33; end
      3'd5: if (b == 0) begin y = a; dz = 1'b1; end else begin y = a % b; lat = 33; end
      3'd4: begin
        lat  = 33;
        full = 1;
        for (longint unsigned i = 0; i < lb; i++) full = (full * la) & 64'hFFFF_FFFF;
        y = full[31:0];
        t = 1;
        if (la >= 2)
          for (longint unsigned i = 0; i < lb; i++) begin
            t = t * la;
            if (t >= 64'h1_0000_0000) begin ovf = 1'b1; break; end
          end
      end
      3'd6: y = a & b;
      default: y = a | b;
    endcase
  endfunction

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 100 && !bus.in_ready; k++) begin @(posedge clk); #1; end
    check({tag, ".in_ready"}, bus.in_ready, 1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input string tag, output logic [31:0] y_obs);
    logic [31:0] ey;
    logic ecy, eovf, edz;
    int elat, lat;
    model(a, b, op, ey, ecy, eovf, edz, elat);
    wait_idle(tag);
    bus.a = a; bus.b = b; bus.oper = op; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.oper = 3'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check({tag, ".lat"}, lat, elat);
    check({tag, ".y"}, bus.y, ey);
    check({tag, ".cy"}, bus.cy, ecy);
    check({tag, ".ovf"}, bus.ovf, eovf);
    check({tag, ".dz"}, bus.dz, edz);
    check({tag, ".zf"}, bus.zf, (ey == 0));
    y_obs = bus.y;
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [31:0] yo;
    logic [31:0] t1_y [8];
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    bit seen;
    t1_y = '{32'd12, 32'd8, 32'd20, 32'd5, 32'd100, 32'd0, 32'd2, 32'd10};

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.oper = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", bus.in_ready, 1);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.y", bus.y, 0);
    check("rst.flags", {bus.cy, bus.ovf, bus.dz, bus.zf}, 4'b0000);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(32'd10, 32'd2, 3'(i), $sformatf("t1.op%0d", i), yo);
      check($sformatf("t1.tab%0d", i), yo, t1_y[i]);
    end

    run_op(32'd2, 32'd10, 3'd1, "sub_wrap", yo);
    check("sub_wrap.tab", yo, 32'hFFFF_FFF8);
    run_op(32'hFFFF_FFFF, 32'd1, 3'd0, "add_carry", yo);
    run_op(32'h1_0000, 32'h1_0000, 3'd2, "mul_ovf", yo);
    run_op(32'd2, 32'd32, 3'd4, "pow_2_32", yo);
    run_op(32'd2, 32'd31, 3'd4, "pow_2_31", yo);
    check("pow_2_31.tab", yo, 32'h8000_0000);
    run_op(32'd0, 32'd0, 3'd4, "pow_0_0", yo);
    check("pow_0_0.tab", yo, 32'd1);
    run_op(32'd0, 32'd7, 3'd4, "pow_0_7", yo);
    run_op(32'd1, 32'd29, 3'd4, "pow_1_29", yo);
    run_op(32'd12345, 32'd0, 3'd4, "pow_x_0", yo);
    run_op(32'd7, 32'd0, 3'd3, "div_zero", yo);
    run_op(32'd7, 32'd0, 3'd5, "mod_zero", yo);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, "div_max", yo);

    // Backpressure: result held, no new accept until after the output handshake.
    wait_idle("bp");
    bus.out_ready = 1'b0;
    bus.a = 32'd5; bus.b = 32'd6; bus.oper = 3'd0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 32'd20; bus.b = 32'd3; bus.oper = 3'd1;
    check("bp.out_valid", bus.out_valid, 1);
    check("bp.y", bus.y, 32'd11);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d", k), {bus.out_valid, bus.in_ready, bus.y, bus.cy, bus.ovf, bus.dz, bus.zf},
            {1'b1, 1'b0, 32'd11, 4'b0000});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.after_hs", {bus.in_ready, bus.out_valid}, 2'b10);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp.next_valid", bus.out_valid, 1);
    check("bp.next_y", bus.y, 32'd17);
    @(posedge clk); #1;

    // Reset in the middle of a divide abandons it.
    wait_idle("rst_div");
    bus.a = 32'd100; bus.b = 32'd7; bus.oper = 3'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_div.ctl", {bus.out_valid, bus.in_ready}, 2'b01);
    check("rst_div.y", bus.y, 0);
    check("rst_div.flags", {bus.cy, bus.ovf, bus.dz, bus.zf}, 4'b0000);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
    check("rst_div.no_result", seen, 0);
    run_op(32'd3, 32'd4, 3'd0, "rst_div.add", yo);
    check("rst_div.add_tab", yo, 32'd7);

    for (int n = 0; n < 150; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if (rop == 3'd4) begin
        if ($urandom_range(0, 1) == 1) ra = $urandom_range(0, 20);
        rb = $urandom_range(0, 40);
      end else if (rop == 3'd3 || rop == 3'd5) begin
        if ($urandom_range(0, 5) == 0) rb = 0;
        else if ($urandom_range(0, 1) == 1) rb = $urandom_range(1, 1000);
      end else if (rop == 3'd2 && $urandom_range(0, 1) == 1) begin
        ra = $urandom_range(0, 70000);
        rb = $urandom_range(0, 70000);
      end
      run_op(ra, rb, rop, $sformatf("rnd%0d.op%0d", n, rop), yo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
